// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared combinational ALU: arbitrates, registers the
// winner's operands, drives the ALU for one cycle and holds each result until it is acknowledged.
module alu_arbiter #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        req0,
  input  logic [31:0] a0,
  input  logic [31:0] b0,
  input  logic [3:0]  op0,
  output logic        gnt0,
  output logic        rvalid0,
  output logic [31:0] res0,
  output logic [2:0]  flags0,
  input  logic        rack0,
  input  logic        req1,
  input  logic [31:0] a1,
  input  logic [31:0] b1,
  input  logic [3:0]  op1,
  output logic        gnt1,
  output logic        rvalid1,
  output logic [31:0] res1,
  output logic [2:0]  flags1,
  input  logic        rack1,
  output logic        busy,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_res,
  input  logic [2:0]  alu_flags
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state_q, state_d;
  logic        owner_q;
  logic        last_owner_q;
  logic        win;
  logic [1:0]  req_v, rack_v, gnt_v;
  logic [1:0]  rvalid_q;
  logic [31:0] alu_a_q, alu_b_q;
  logic [3:0]  alu_op_q;
  logic [31:0] res0_q, res1_q;
  logic [2:0]  flags0_q, flags1_q;

  assign req_v  = {req1, req0};
  assign rack_v = {rack1, rack0};

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    gnt_v   = 2'b00;
    win     = 1'b0;
    case (state_q)
      IDLE: begin
        // A tie goes to requester 0 under fixed priority, else to whoever was not served last.
        win = req_v[1] & (~req_v[0] | (~FIXED_PRIO & ~last_owner_q));
        if (|req_v) begin
          gnt_v   = win ? 2'b10 : 2'b01;
          state_d = EXEC;
        end
      end
      EXEC:    state_d = RESP;
      RESP:    if (rack_v[owner_q]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      rvalid_q     <= 2'b00;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= 4'h0;
      res0_q       <= '0;
      res1_q       <= '0;
      flags0_q     <= '0;
      flags1_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req_v) begin
            alu_a_q      <= win ? a1  : a0;
            alu_b_q      <= win ? b1  : b0;
            alu_op_q     <= win ? op1 : op0;
            owner_q      <= win;
            last_owner_q <= win;
          end
        end
        EXEC: begin
          if (owner_q) begin
            res1_q   <= alu_res;
            flags1_q <= alu_flags;
          end else begin
            res0_q   <= alu_res;
            flags0_q <= alu_flags;
          end
          rvalid_q[owner_q] <= 1'b1;
        end
        RESP: begin
          if (rack_v[owner_q]) rvalid_q[owner_q] <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign gnt0    = gnt_v[0];
  assign gnt1    = gnt_v[1];
  assign rvalid0 = rvalid_q[0];
  assign rvalid1 = rvalid_q[1];
  assign res0    = res0_q;
  assign res1    = res1_q;
  assign flags0  = flags0_q;
  assign flags1  = flags1_q;
  assign busy    = (state_q != IDLE);
  assign alu_a   = alu_a_q;
  assign alu_b   = alu_b_q;
  assign alu_op  = alu_op_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: instance 0 round-robin, instance 1 fixed priority, each with a
// behavioural ALU stub; directed scenarios followed by random traffic against a timestamp model.
module tb_alu_arbiter;

  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3, OP_XOR = 4'd4;
  localparam longint MAX_S = 64'sh7FFF_FFFF;
  localparam longint MIN_S = -64'sh8000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  req  [2];
  logic [1:0]  rack [2];
  logic [31:0] a_in [2][2];
  logic [31:0] b_in [2][2];
  logic [3:0]  op_in [2][2];

  wire  [1:0]  gnt [2];
  wire  [1:0]  rvalid [2];
  wire  [31:0] res [2][2];
  wire  [2:0]  flags [2][2];
  wire         busy [2];
  wire  [31:0] alu_a [2];
  wire  [31:0] alu_b [2];
  wire  [3:0]  alu_op [2];
  wire  [31:0] alu_res [2];
  wire  [2:0]  alu_flags [2];

  int n_tests = 0;
  int n_fail  = 0;

  // Returns {negative, overflow, zero, result}; ops beyond XOR pass port_a through.
  function automatic logic [34:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op);
    longint sa, sb, full;
    logic [31:0] r;
    logic ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ovf = 1'b0;
    case (op)
      OP_ADD:  begin full = sa + sb; r = full[31:0]; ovf = (full > MAX_S) || (full < MIN_S); end
      OP_SUB:  begin full = sa - sb; r = full[31:0]; ovf = (full > MAX_S) || (full < MIN_S); end
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      default: r = a;
    endcase
    return {r[31], ovf, (r == 32'd0), r};
  endfunction

  for (genvar k = 0; k < 2; k++) begin : g_dut
    alu_arbiter #(.FIXED_PRIO(k != 0)) u_dut (
      .CLK(clk), .nRST(rst_n),
      .req0(req[k][0]), .a0(a_in[k][0]), .b0(b_in[k][0]), .op0(op_in[k][0]),
      .gnt0(gnt[k][0]), .rvalid0(rvalid[k][0]), .res0(res[k][0]), .flags0(flags[k][0]),
      .rack0(rack[k][0]),
      .req1(req[k][1]), .a1(a_in[k][1]), .b1(b_in[k][1]), .op1(op_in[k][1]),
      .gnt1(gnt[k][1]), .rvalid1(rvalid[k][1]), .res1(res[k][1]), .flags1(flags[k][1]),
      .rack1(rack[k][1]),
      .busy(busy[k]), .alu_a(alu_a[k]), .alu_b(alu_b[k]), .alu_op(alu_op[k]),
      .alu_res(alu_res[k]), .alu_flags(alu_flags[k])
    );
    assign {alu_flags[k], alu_res[k]} = ref_alu(alu_a[k], alu_b[k], alu_op[k]);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    for (int k = 0; k < 2; k++) begin
      req[k]  = 2'b00;
      rack[k] = 2'b00;
      for (int n = 0; n < 2; n++) begin
        a_in[k][n]  = '0;
        b_in[k][n]  = '0;
        op_in[k][n] = '0;
      end
    end
  endtask

  task automatic do_reset();
    clear_inputs();
    mid();
    rst_n = 1'b0;
    tick();
    mid();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic set_op(input int k, input int n, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] op);
    a_in[k][n]  = a;
    b_in[k][n]  = b;
    op_in[k][n] = op;
    req[k][n]   = 1'b1;
  endtask

  // Raises reqN (called in an IDLE cycle), expects the grant now, the response two cycles later,
  // acknowledges it and returns at the start of the following IDLE cycle.
  task automatic serve(input int k, input int n, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] op, input string tag);
    logic [34:0] e;
    logic [1:0]  w;
    e = ref_alu(a, b, op);
    w = (n == 0) ? 2'b01 : 2'b10;
    set_op(k, n, a, b, op);
    mid();
    check({tag, " gnt"}, gnt[k], w);
    tick();
    req[k][n] = 1'b0;
    mid();
    check({tag, " exec busy"}, busy[k], 1'b1);
    check({tag, " exec rvalid"}, rvalid[k], 2'b00);
    check({tag, " alu operands"}, {alu_op[k], alu_a[k], alu_b[k]}, {op, a, b});
    tick();
    mid();
    check({tag, " rvalid"}, rvalid[k], w);
    check({tag, " res"}, res[k][n], e[31:0]);
    check({tag, " flags"}, flags[k][n], e[34:32]);
    rack[k][n] = 1'b1;
    tick();
    rack[k][n] = 1'b0;
  endtask

  // Random-phase model: an op occupies the arbiter from its grant until the acknowledge edge,
  // and its response is visible from two cycles after the grant.
  bit          m_busy [2];
  int          m_owner [2];
  int          m_tgrant [2];
  int          m_last [2];
  logic [34:0] m_exp [2];
  logic [1:0]  m_granted [2];

  initial begin
    clear_inputs();
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("reset k%0d gnt", k), gnt[k], 2'b00);
      check($sformatf("reset k%0d rvalid", k), rvalid[k], 2'b00);
      check($sformatf("reset k%0d busy", k), busy[k], 1'b0);
      check($sformatf("reset k%0d alu regs", k), {alu_op[k], alu_a[k], alu_b[k]}, 68'h0);
      check($sformatf("reset k%0d res/flags", k),
            {flags[k][1], flags[k][0], res[k][1][31:0], res[k][0][31:0]}, 70'h0);
    end
    mid();
    rst_n = 1'b1;
    tick();

    // Basic ADD with immediate acknowledge; response then drops and result is held.
    serve(0, 0, 32'd5, 32'd7, OP_ADD, "add");
    mid();
    check("add after rack rvalid", rvalid[0], 2'b00);
    check("add after rack busy", busy[0], 1'b0);
    check("add held res", res[0][0], 32'd12);
    check("add held flags", flags[0][0], 3'b000);
    tick();

    // Round-robin alternation from a fresh reset.
    do_reset();
    set_op(0, 1, 32'h10, 32'h3, OP_XOR);
    serve(0, 0, 32'hF0, 32'h0F, OP_OR, "rr tie1 req0");
    serve(0, 1, 32'h10, 32'h3, OP_XOR, "rr then req1");
    set_op(0, 1, 32'd3, 32'd3, OP_SUB);
    serve(0, 0, 32'hFFFF_FFFF, 32'd1, OP_ADD, "rr tie2 req0");
    check("rr zero flag", flags[0][0], 3'b001);
    serve(0, 1, 32'd3, 32'd3, OP_SUB, "rr tie2 req1");

    // Fixed priority: requester 0 keeps winning while requester 1 waits.
    set_op(1, 1, 32'd1, 32'd2, OP_AND);
    for (int i = 0; i < 4; i++) begin
      serve(1, 0, $urandom, $urandom, 4'($urandom_range(0, 4)), $sformatf("fp op%0d", i));
    end
    serve(1, 1, 32'd1, 32'd2, OP_AND, "fp req1 last");

    // Signed overflow on subtraction.
    serve(0, 0, 32'h8000_0000, 32'd1, OP_SUB, "sub ovf");
    check("sub ovf res const", res[0][0], 32'h7FFF_FFFF);
    check("sub ovf flags const", flags[0][0], 3'b010);

    // Held response blocks the pending requester; a rack on the idle port is ignored.
    set_op(0, 0, 32'd100, 32'd23, OP_ADD);
    mid();
    check("hold gnt0", gnt[0], 2'b01);
    tick();
    req[0][0] = 1'b0;
    set_op(0, 1, 32'hFF00, 32'h0FF0, OP_AND);
    mid();
    check("hold exec gnt", gnt[0], 2'b00);
    tick();
    for (int i = 0; i < 5; i++) begin
      rack[0][1] = (i == 2);
      mid();
      check($sformatf("hold c%0d rvalid", i), rvalid[0], 2'b01);
      check($sformatf("hold c%0d res0", i), res[0][0], 32'd123);
      check($sformatf("hold c%0d gnt", i), gnt[0], 2'b00);
      tick();
    end
    rack[0][1] = 1'b0;
    rack[0][0] = 1'b1;
    tick();
    rack[0][0] = 1'b0;
    mid();
    check("hold release gnt1", gnt[0], 2'b10);
    check("hold release rvalid", rvalid[0], 2'b00);
    tick();
    req[0][1] = 1'b0;
    tick();
    mid();
    check("hold req1 rvalid", rvalid[0], 2'b10);
    check("hold req1 res", res[0][1], 32'h0F00);
    rack[0][1] = 1'b1;
    tick();
    rack[0][1] = 1'b0;

    // Asynchronous reset in the middle of EXEC drops the op.
    set_op(0, 0, 32'd9, 32'd9, OP_ADD);
    mid();
    check("rst gnt", gnt[0], 2'b01);
    tick();
    req[0][0] = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst busy", busy[0], 1'b0);
    check("rst rvalid", rvalid[0], 2'b00);
    check("rst alu regs", {alu_op[0], alu_a[0], alu_b[0]}, 68'h0);
    check("rst res/flags", {flags[0][1], flags[0][0], res[0][1], res[0][0]}, 70'h0);
    mid();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      mid();
      check($sformatf("post rst c%0d rvalid/busy", i), {rvalid[0], busy[0]}, 3'b000);
    end
    tick();
    serve(0, 0, 32'd40, 32'd2, OP_ADD, "post rst add");

    // Random traffic on both instances against the model.
    do_reset();
    for (int k = 0; k < 2; k++) begin
      m_busy[k] = 1'b0;
      m_last[k] = 1;
      m_granted[k] = 2'b00;
    end
    for (int cyc = 0; cyc < 300; cyc++) begin
      for (int k = 0; k < 2; k++) begin
        for (int n = 0; n < 2; n++) begin
          if (m_granted[k][n]) req[k][n] = 1'b0;
          else if (!req[k][n] && $urandom_range(0, 2) == 0)
            set_op(k, n, $urandom, ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom,
                   4'($urandom_range(0, 7)));
          rack[k][n] = 1'($urandom_range(0, 1));
        end
      end
      mid();
      for (int k = 0; k < 2; k++) begin
        int w;
        logic [1:0] eg, er;
        eg = 2'b00;
        er = 2'b00;
        w  = 0;
        if (!m_busy[k] && req[k] != 2'b00) begin
          if (req[k] == 2'b11) w = (k == 1) ? 0 : 1 - m_last[k];
          else                 w = req[k][1] ? 1 : 0;
          eg[w] = 1'b1;
        end
        if (m_busy[k] && cyc >= m_tgrant[k] + 2) er[m_owner[k]] = 1'b1;
        check($sformatf("rand%0d k%0d gnt", cyc, k), gnt[k], eg);
        check($sformatf("rand%0d k%0d rvalid", cyc, k), rvalid[k], er);
        check($sformatf("rand%0d k%0d busy", cyc, k), busy[k], m_busy[k]);
        if (er != 2'b00)
          check($sformatf("rand%0d k%0d resp", cyc, k),
                {flags[k][m_owner[k]], res[k][m_owner[k]]}, m_exp[k]);
        m_granted[k] = eg;
        if (eg != 2'b00) begin
          m_busy[k]   = 1'b1;
          m_owner[k]  = w;
          m_tgrant[k] = cyc;
          m_last[k]   = w;
          m_exp[k]    = ref_alu(a_in[k][w], b_in[k][w], op_in[k][w]);
        end else if (er != 2'b00 && rack[k][m_owner[k]]) begin
          m_busy[k] = 1'b0;
        end
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
